// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
// The request is held with stable address, data and direction until a one-cycle ack pulse.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: performs loads/stores over a req/ack bus and loads MEM/WB; non-memory ops take 1 cycle,
// memory ops 1 + ack-delay cycles with stall held meanwhile, abandoned after TIMEOUT WAIT cycles.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic [31:0]               rt_data,
  input  logic [4:0]                WriteAddr,
  input  logic [1:0]                MemtoReg,
  input  logic                      RegWrite,
  input  logic [31:0]               ALUOut,
  input  logic [31:0]               pc_plus_4,
  mem_access_stage_if.master        mem,
  output logic                      stall,
  output logic                      wb_valid,
  output logic                      wb_RegWrite,
  output logic [4:0]                wb_WriteAddr,
  output logic [31:0]               wb_WriteData,
  output logic [31:0]               fwd_data,
  output logic                      misalign_err,
  output logic                      bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          mem_acc, mem_op, misaligned;
  logic          req, timeout;
  logic [31:0]   addr_q, wdata_q, sel_q;
  logic          we_q, rw_q, rd_sel_q;
  logic [4:0]    wa_q;

  assign mem_acc    = in_valid & (MemRead | MemWrite);
  assign mem_op     = mem_acc & (ALUOut[1:0] == 2'b00);
  assign misaligned = mem_acc & (ALUOut[1:0] != 2'b00);
  assign fwd_data   = (MemtoReg == 2'b10) ? pc_plus_4 : ALUOut;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_IDLE) begin
      if (mem_op) state_nxt = S_WAIT;
    end else begin
      if (mem.mem_ack || timeout) state_nxt = S_IDLE;
    end
  end

  // An ack on the final counted cycle wins over the timeout.
  always_comb begin
    req     = 1'b0;
    timeout = 1'b0;
    stall   = 1'b0;
    if (state == S_IDLE) begin
      stall = mem_op;
    end else begin
      req     = 1'b1;
      timeout = ~mem.mem_ack & (cnt == CW'(TIMEOUT - 1));
      stall   = ~mem.mem_ack & ~timeout;
    end
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      rw_q     <= 1'b0;
      rd_sel_q <= 1'b0;
      wa_q     <= '0;
    end else if (state == S_IDLE) begin
      if (mem_op) begin
        cnt      <= '0;
        addr_q   <= {ALUOut[31:2], 2'b00};
        wdata_q  <= rt_data;
        sel_q    <= fwd_data;
        we_q     <= MemWrite;
        rw_q     <= RegWrite;
        rd_sel_q <= MemRead & (MemtoReg == 2'b01);
        wa_q     <= WriteAddr;
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // MEM/WB gets a bubble every cycle the access is still outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_RegWrite  <= 1'b0;
      wb_WriteAddr <= '0;
      wb_WriteData <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_err <= (state == S_IDLE) & misaligned;
      if (timeout) bus_err <= 1'b1;
      if (state == S_IDLE) begin
        wb_valid     <= in_valid & ~mem_op;
        wb_RegWrite  <= in_valid & ~mem_acc & RegWrite;
        wb_WriteAddr <= WriteAddr;
        wb_WriteData <= fwd_data;
      end else begin
        wb_valid     <= mem.mem_ack | timeout;
        wb_RegWrite  <= mem.mem_ack & rw_q;
        wb_WriteAddr <= wa_q;
        wb_WriteData <= (mem.mem_ack & rd_sel_q) ? mem.mem_rdata : sel_q;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT = 4): ALU, load, store, jal, misalign, back-to-back, timeout, reset.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, MemRead, MemWrite, RegWrite;
  logic [31:0] rt_data, ALUOut, pc_plus_4;
  logic [4:0]  WriteAddr;
  logic [1:0]  MemtoReg;
  logic        stall, wb_valid, wb_RegWrite, misalign_err, bus_err;
  logic [4:0]  wb_WriteAddr;
  logic [31:0] wb_WriteData, fwd_data;
  int          vectors = 0;
  int          miscompares = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .rt_data(rt_data), .WriteAddr(WriteAddr), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUOut(ALUOut), .pc_plus_4(pc_plus_4), .mem(bus), .stall(stall), .wb_valid(wb_valid),
    .wb_RegWrite(wb_RegWrite), .wb_WriteAddr(wb_WriteAddr), .wb_WriteData(wb_WriteData),
    .fwd_data(fwd_data), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [31:0] alu, input logic [31:0] rt,
                        input logic [31:0] pc4, input logic [4:0] wa, input logic [1:0] m2r, input logic rw);
    in_valid  = 1'b1;
    MemRead   = rd;
    MemWrite  = wr;
    ALUOut    = alu;
    rt_data   = rt;
    pc_plus_4 = pc4;
    WriteAddr = wa;
    MemtoReg  = m2r;
    RegWrite  = rw;
  endtask

  task automatic bubble;
    in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
    ALUOut = '0; rt_data = '0; pc_plus_4 = '0; WriteAddr = '0; MemtoReg = 2'b00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bubble();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    #12;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset mem_req: got %b want 0", bus.mem_req); end
    vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL reset mem_we: got %b want 0", bus.mem_we); end
    vectors++; if (bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset mem_addr: got %h want 0", bus.mem_addr); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset stall: got %b want 0", stall); end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset wb_valid: got %b want 0", wb_valid); end
    vectors++; if (wb_WriteData !== 32'h0) begin miscompares++; $display("FAIL reset wb_WriteData: got %h want 0", wb_WriteData); end
    vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL reset bus_err: got %b want 0", bus_err); end
    vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL reset misalign_err: got %b want 0", misalign_err); end
    rst = 1'b0;
  endtask

  task automatic test_alu;
    tick(); set_op(1'b0, 1'b0, 32'h12, 32'h0, 32'h0, 5'd8, 2'b00, 1'b1); #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL alu stall: got %b want 0", stall); end
    vectors++; if (fwd_data !== 32'h12) begin miscompares++; $display("FAIL alu fwd_data: got %h want 12", fwd_data); end
    tick(); set_op(1'b0, 1'b0, 32'h34, 32'h0, 32'h0, 5'd9, 2'b01, 1'b1); #1;
    vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL alu wb_valid: got %b want 1", wb_valid); end
    vectors++; if (wb_WriteData !== 32'h12) begin miscompares++; $display("FAIL alu wb_WriteData: got %h want 12", wb_WriteData); end
    vectors++; if (wb_WriteAddr !== 5'd8) begin miscompares++; $display("FAIL alu wb_WriteAddr: got %0d want 8", wb_WriteAddr); end
    vectors++; if (wb_RegWrite !== 1'b1) begin miscompares++; $display("FAIL alu wb_RegWrite: got %b want 1", wb_RegWrite); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL alu2 stall: got %b want 0", stall); end
    tick(); bubble(); #1;
    vectors++; if (wb_WriteData !== 32'h34) begin miscompares++; $display("FAIL alu m2r01 wb_WriteData: got %h want 34", wb_WriteData); end
    tick(); #1;
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL bubble wb_valid: got %b want 0", wb_valid); end
  endtask

  task automatic test_load;
    tick(); set_op(1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 5'd5, 2'b01, 1'b1); #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL load idle stall: got %b want 1", stall); end
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL load idle mem_req: got %b want 0", bus.mem_req); end
    tick(); #1;
    vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL load w1 mem_req: got %b want 1", bus.mem_req); end
    vectors++; if (bus.mem_addr !== 32'h100) begin miscompares++; $display("FAIL load mem_addr: got %h want 100", bus.mem_addr); end
    vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL load mem_we: got %b want 0", bus.mem_we); end
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL load w1 stall: got %b want 1", stall); end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL load w1 wb_valid: got %b want 0", wb_valid); end
    tick(); #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL load w2 stall: got %b want 1", stall); end
    tick(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF; #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL load ack stall: got %b want 0", stall); end
    vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL load ack mem_req: got %b want 1", bus.mem_req); end
    tick(); bus.mem_ack = 1'b0; bus.mem_rdata = '0; bubble(); #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL load done mem_req: got %b want 0", bus.mem_req); end
    vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL load wb_valid: got %b want 1", wb_valid); end
    vectors++; if (wb_WriteData !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load wb_WriteData: got %h want deadbeef", wb_WriteData); end
    vectors++; if (wb_RegWrite !== 1'b1) begin miscompares++; $display("FAIL load wb_RegWrite: got %b want 1", wb_RegWrite); end
    vectors++; if (wb_WriteAddr !== 5'd5) begin miscompares++; $display("FAIL load wb_WriteAddr: got %0d want 5", wb_WriteAddr); end
  endtask

  task automatic test_store;
    tick(); set_op(1'b0, 1'b1, 32'h40, 32'h55AA, 32'h0, 5'd0, 2'b00, 1'b0); #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL store idle stall: got %b want 1", stall); end
    tick(); bus.mem_ack = 1'b1; #1;
    vectors++; if (bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL store mem_we: got %b want 1", bus.mem_we); end
    vectors++; if (bus.mem_wdata !== 32'h55AA) begin miscompares++; $display("FAIL store mem_wdata: got %h want 55aa", bus.mem_wdata); end
    vectors++; if (bus.mem_addr !== 32'h40) begin miscompares++; $display("FAIL store mem_addr: got %h want 40", bus.mem_addr); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL store ack stall: got %b want 0", stall); end
    tick(); bus.mem_ack = 1'b0; bubble(); #1;
    vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL store wb_valid: got %b want 1", wb_valid); end
    vectors++; if (wb_RegWrite !== 1'b0) begin miscompares++; $display("FAIL store wb_RegWrite: got %b want 0", wb_RegWrite); end
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL store done mem_req: got %b want 0", bus.mem_req); end
  endtask

  task automatic test_jal;
    tick(); set_op(1'b0, 1'b0, 32'h999, 32'h0, 32'h400, 5'd31, 2'b10, 1'b1); #1;
    vectors++; if (fwd_data !== 32'h400) begin miscompares++; $display("FAIL jal fwd_data: got %h want 400", fwd_data); end
    tick(); bubble(); #1;
    vectors++; if (wb_WriteData !== 32'h400) begin miscompares++; $display("FAIL jal wb_WriteData: got %h want 400", wb_WriteData); end
    vectors++; if (wb_WriteAddr !== 5'd31) begin miscompares++; $display("FAIL jal wb_WriteAddr: got %0d want 31", wb_WriteAddr); end
  endtask

  task automatic test_misalign;
    tick(); set_op(1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 5'd3, 2'b01, 1'b1); #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL misalign stall: got %b want 0", stall); end
    tick(); bubble(); #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL misalign mem_req: got %b want 0", bus.mem_req); end
    vectors++; if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL misalign_err pulse: got %b want 1", misalign_err); end
    vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL misalign wb_valid: got %b want 1", wb_valid); end
    vectors++; if (wb_RegWrite !== 1'b0) begin miscompares++; $display("FAIL misalign wb_RegWrite: got %b want 0", wb_RegWrite); end
    tick(); #1;
    vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL misalign_err clear: got %b want 0", misalign_err); end
  endtask

  task automatic test_back_to_back;
    tick(); set_op(1'b1, 1'b0, 32'h200, 32'h0, 32'h0, 5'd1, 2'b01, 1'b1); #1;
    tick(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11111111; #1;
    vectors++; if (bus.mem_addr !== 32'h200) begin miscompares++; $display("FAIL b2b A mem_addr: got %h want 200", bus.mem_addr); end
    tick(); bus.mem_ack = 1'b0; set_op(1'b1, 1'b0, 32'h204, 32'h0, 32'h0, 5'd2, 2'b01, 1'b1); #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL b2b gap mem_req: got %b want 0", bus.mem_req); end
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL b2b B stall: got %b want 1", stall); end
    vectors++; if (wb_WriteData !== 32'h11111111) begin miscompares++; $display("FAIL b2b A wb_WriteData: got %h want 11111111", wb_WriteData); end
    tick(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h22222222; #1;
    vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL b2b B mem_req: got %b want 1", bus.mem_req); end
    vectors++; if (bus.mem_addr !== 32'h204) begin miscompares++; $display("FAIL b2b B mem_addr: got %h want 204", bus.mem_addr); end
    // Stray ack while IDLE with a bubble in the slot.
    tick(); bubble(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0; #1;
    vectors++; if (wb_WriteData !== 32'h22222222) begin miscompares++; $display("FAIL b2b B wb_WriteData: got %h want 22222222", wb_WriteData); end
    vectors++; if (wb_WriteAddr !== 5'd2) begin miscompares++; $display("FAIL b2b B wb_WriteAddr: got %0d want 2", wb_WriteAddr); end
    tick(); bus.mem_ack = 1'b0; #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL idle ack mem_req: got %b want 0", bus.mem_req); end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL idle ack wb_valid: got %b want 0", wb_valid); end
  endtask

  task automatic test_timeout_ack;
    tick(); set_op(1'b1, 1'b0, 32'h300, 32'h0, 32'h0, 5'd6, 2'b01, 1'b1); #1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE0001; #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL late ack stall: got %b want 0", stall); end
    tick(); bus.mem_ack = 1'b0; bubble(); #1;
    vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL late ack bus_err: got %b want 0", bus_err); end
    vectors++; if (wb_WriteData !== 32'hCAFE0001) begin miscompares++; $display("FAIL late ack wb_WriteData: got %h want cafe0001", wb_WriteData); end
    vectors++; if (wb_RegWrite !== 1'b1) begin miscompares++; $display("FAIL late ack wb_RegWrite: got %b want 1", wb_RegWrite); end
  endtask

  task automatic test_timeout;
    int req_cycles;
    req_cycles = 0;
    tick(); set_op(1'b1, 1'b0, 32'h80, 32'h0, 32'h0, 5'd7, 2'b01, 1'b1); #1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      if (bus.mem_req === 1'b1) req_cycles++;
      vectors++; if (stall !== (i < 3)) begin miscompares++; $display("FAIL timeout stall cyc%0d: got %b want %b", i, stall, (i < 3)); end
    end
    vectors++; if (req_cycles !== 4) begin miscompares++; $display("FAIL timeout req cycles: got %0d want 4", req_cycles); end
    tick(); bubble(); #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL timeout mem_req: got %b want 0", bus.mem_req); end
    vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL timeout bus_err: got %b want 1", bus_err); end
    vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL timeout wb_valid: got %b want 1", wb_valid); end
    vectors++; if (wb_RegWrite !== 1'b0) begin miscompares++; $display("FAIL timeout wb_RegWrite: got %b want 0", wb_RegWrite); end
    tick(); set_op(1'b0, 1'b0, 32'h5, 32'h0, 32'h0, 5'd4, 2'b00, 1'b1); #1;
    tick(); bubble(); #1;
    vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL bus_err sticky: got %b want 1", bus_err); end
  endtask

  task automatic test_rst_in_wait;
    tick(); set_op(1'b1, 1'b0, 32'h500, 32'h0, 32'h0, 5'd9, 2'b01, 1'b1); #1;
    tick(); #1;
    vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL rstwait pre mem_req: got %b want 1", bus.mem_req); end
    bubble(); rst = 1'b1; #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rstwait async mem_req: got %b want 0", bus.mem_req); end
    vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL rstwait bus_err: got %b want 0", bus_err); end
    @(negedge clk); rst = 1'b0;
    tick(); #1;
    vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rstwait post mem_req: got %b want 0", bus.mem_req); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rstwait post stall: got %b want 0", stall); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_jal();
    test_misalign();
    test_back_to_back();
    test_timeout_ack();
    test_timeout();
    test_rst_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM stage of the five-stage pipelined CPU: the consumer of the EX/MEM pipeline register. It takes the latched EX results, performs the data-memory load or store over a request/acknowledge bus, stalls the front of the pipeline until the access completes, and loads the MEM/WB register. Every load and store goes through one handshake, with a bounded wait and error flags. The write-back value also serves as the MEM-stage forwarding source.

## Interface
- TIMEOUT, 16: maximum cycles in WAIT without mem_ack before the access is abandoned (≥1).
- clk  in  1  pipeline clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX/MEM slot holds a real instruction (0 = bubble).
- MemRead  in  1  load.
- MemWrite  in  1  store; MemRead and MemWrite never both 1.
- rt_data  in  32  store data.
- WriteAddr  in  5  destination register.
- MemtoReg  in  2  write-back source: 00 = ALUOut, 01 = memory data, 10 = pc_plus_4, 11 = ALUOut.
- RegWrite  in  1  destination write enable.
- ALUOut  in  32  ALU result or byte address.
- pc_plus_4  in  32  link value.
- mem_req  out  1  bus request, held until ack or timeout.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned byte address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- wb_valid  out  1  MEM/WB slot holds a real instruction.
- wb_RegWrite  out  1  MEM/WB register write enable.
- wb_WriteAddr  out  5  MEM/WB destination register.
- wb_WriteData  out  32  MEM/WB selected write-back value.
- fwd_data  out  32  combinational MEM-stage forward value: pc_plus_4 if MemtoReg = 10, else ALUOut.
- misalign_err  out  1  one-cycle pulse: memory op with ALUOut[1:0] ≠ 0.
- bus_err  out  1  sticky timeout flag, cleared only by rst.

## Operation
- memop = in_valid & (MemRead | MemWrite) & (ALUOut[1:0] == 0).
- FSM states are IDLE and WAIT; reset state is IDLE.
- IDLE, non-memory valid instruction:
  - At the edge, the MEM/WB register loads wb_valid = 1, wb_RegWrite = RegWrite, wb_WriteAddr = WriteAddr.
  - wb_WriteData follows MemtoReg (01 is treated as ALUOut when no access was made).
- IDLE, in_valid = 0: MEM/WB loads a bubble (wb_valid = 0, wb_RegWrite = 0).
- IDLE, misaligned memory op:
  - No bus request.
  - misalign_err = 1 next cycle, for one cycle.
  - MEM/WB loads wb_valid = 1, wb_RegWrite = 0; the write is squashed.
- IDLE, memop:
  - stall = 1 this cycle.
  - Latch address, write data, mem_we = MemWrite, plus the write-back control fields.
  - Go to WAIT; MEM/WB loads a bubble.
- WAIT:
  - mem_req = 1 with latched mem_we, mem_addr and mem_wdata held stable.
  - The wait counter increments every cycle.
  - stall = ~mem_ack.
- WAIT with mem_ack:
  - MEM/WB loads the latched fields, wb_valid = 1.
  - wb_WriteData = mem_rdata for a load with MemtoReg = 01, otherwise the latched selection.
  - Stores load wb_RegWrite = latched RegWrite, normally 0.
  - Return to IDLE.
- WAIT timeout: counter reaches TIMEOUT with no ack:
  - Drop mem_req, set bus_err.
  - MEM/WB loads wb_valid = 1, wb_RegWrite = 0.
  - stall = 0 that cycle; return to IDLE.
  - An ack on the timeout cycle takes priority: a normal completion, no error.
- mem_ack in IDLE is ignored.
- The counter clears on entering WAIT; it is $clog2(TIMEOUT+1) bits wide.

## Timing
- Reset values (asynchronous):
  - state IDLE.
  - mem_req, mem_we, stall-related state, wb_valid, wb_RegWrite, misalign_err, bus_err = 0.
  - mem_addr, mem_wdata, wb_WriteAddr, wb_WriteData, counter = 0.
- Reset mid-WAIT drops mem_req immediately, without waiting for a clock edge.
- Non-memory instruction: 1 cycle in the stage, no stall.
- Memory op: 1 IDLE cycle plus N WAIT cycles, where N is the ack delay (≥1). Minimum 2 cycles; stall asserted for N cycles.
- mem_req rises on the edge after the memop is seen in IDLE. It falls on the edge after ack or timeout.
- stall is combinational from state, inputs and mem_ack; all wb_* outputs are registered.
- Back-to-back memory ops: the second enters IDLE on the ack edge. A new request starts one cycle later, so mem_req is low for exactly one cycle between them.

## Test plan
- ALU op: ALUOut = 0x12, RegWrite = 1, WriteAddr = 8, MemtoReg = 00 -> next cycle wb_valid = 1, wb_WriteData = 0x12, wb_WriteAddr = 8, stall never 1.
- Load at 0x100, ack 3 cycles after mem_req rises, mem_rdata = 0xDEADBEEF:
  - stall high for 3 cycles; mem_addr = 0x100, mem_we = 0.
  - wb_WriteData = 0xDEADBEEF after the ack edge.
- Store at 0x40, rt_data = 0x55AA, ack in the first WAIT cycle -> mem_we = 1, mem_wdata = 0x55AA, total stall 1 cycle, wb_RegWrite = 0.
- jal-style op: MemtoReg = 10, pc_plus_4 = 0x400 -> fwd_data = 0x400 in the same cycle, wb_WriteData = 0x400.
- Misaligned load, ALUOut = 0x102 -> no mem_req, misalign_err one-cycle pulse, wb_RegWrite = 0.
- Faults:
  - TIMEOUT = 4, no ack -> mem_req drops after 4 WAIT cycles, bus_err = 1 and stays set.
  - rst asserted in WAIT -> mem_req = 0 immediately.
